// File: rtl/mult_ctrl_pkg.sv
// Shared state encoding for the 4x4 shift-add multiplier controller.
// Imported by the present-state generator and by the output decoder.
package mult_ctrl_pkg;

   localparam logic [2:0] PS_IDLE  = 3'b000;
   localparam logic [2:0] PS_CLR   = 3'b001;
   localparam logic [2:0] PS_LOAD  = 3'b010;
   localparam logic [2:0] PS_ADD   = 3'b011;
   localparam logic [2:0] PS_SHIFT = 3'b100;
   localparam logic [2:0] PS_LAST  = 3'b101;
   localparam logic [2:0] PS_DONE  = 3'b110;
   localparam logic [2:0] PS_CHECK = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE  = PS_IDLE,
      S_CLR   = PS_CLR,
      S_LOAD  = PS_LOAD,
      S_ADD   = PS_ADD,
      S_SHIFT = PS_SHIFT,
      S_LAST  = PS_LAST,
      S_DONE  = PS_DONE,
      S_CHECK = PS_CHECK
   } state_t;

   function automatic logic ps_is_active(input logic [2:0] code);
      return (code != PS_IDLE);
   endfunction

endpackage

// File: rtl/iter_counter.sv
// Iteration counter for the multiplier sequencer: clear, enable, and a
// terminal flag that is high when the next increment reaches WIDTH.
module iter_counter #(
   parameter int WIDTH = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_last
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [CW-1:0] r_count;
   logic [CW-1:0] w_count_inc;

   assign w_count_inc = r_count + CW'(1);
   assign o_last      = (w_count_inc == CW'(WIDTH));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_en) begin
         r_count <= w_count_inc;
      end else begin
         r_count <= r_count;
      end
   end

endmodule

// File: rtl/multiplier_sequencer.sv
// Present-state generator for the shift-add multiplier controller.
// Optional early termination on zero remaining bits: MULT_SEQ_EARLY_TERM_EN.
module multiplier_sequencer
   import mult_ctrl_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       lsb,
   input  logic       rem_zero,
   output logic [2:0] ps,
   output logic       busy,
   output logic       done
);

   state_t r_state;
   state_t w_next;
   logic   w_cnt_last;
   logic   w_cnt_clr;
   logic   w_cnt_en;

`ifndef MULT_SEQ_EARLY_TERM_EN
   logic w_unused_rem_zero;
   assign w_unused_rem_zero = rem_zero;
`endif

   assign w_cnt_clr = (r_state == S_CLR);
   assign w_cnt_en  = (r_state == S_SHIFT);

   iter_counter #(
      .WIDTH (WIDTH)
   ) u_iter_counter (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (w_cnt_clr),
      .i_en   (w_cnt_en),
      .o_last (w_cnt_last)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next = S_CLR;
            end else begin
               w_next = S_IDLE;
            end
         end
         S_CLR:   w_next = S_LOAD;
         S_LOAD:  w_next = S_CHECK;
         // lsb is already updated here: CHECK always follows LOAD or SHIFT
         S_CHECK: begin
`ifdef MULT_SEQ_EARLY_TERM_EN
            if (rem_zero) begin
               w_next = S_LAST;
            end else if (lsb) begin
               w_next = S_ADD;
            end else begin
               w_next = S_SHIFT;
            end
`else
            if (lsb) begin
               w_next = S_ADD;
            end else begin
               w_next = S_SHIFT;
            end
`endif
         end
         S_ADD:   w_next = S_SHIFT;
         S_SHIFT: begin
            if (w_cnt_last) begin
               w_next = S_LAST;
            end else begin
               w_next = S_CHECK;
            end
         end
         S_LAST:  w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   assign ps   = r_state;
   assign busy = ps_is_active(r_state);
   assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_multiplier_sequencer.sv
// Scoreboard bench for multiplier_sequencer: a datapath stand-in drives lsb and
// rem_zero, a trace model fills the expected queue, a monitor compares ps/busy/done.
module tb_multiplier_sequencer;

   localparam int W = 4;
   localparam logic [2:0] IDLE  = 3'b000;
   localparam logic [2:0] CLR   = 3'b001;
   localparam logic [2:0] LOAD  = 3'b010;
   localparam logic [2:0] ADD   = 3'b011;
   localparam logic [2:0] SHIFT = 3'b100;
   localparam logic [2:0] LAST  = 3'b101;
   localparam logic [2:0] DONE  = 3'b110;
   localparam logic [2:0] CHECK = 3'b111;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          lsb;
   logic          rem_zero;
   logic [2:0]    ps;
   logic          busy;
   logic          done;
   logic [W-1:0]  mreg = '0;
   logic [W-1:0]  mult_in = '0;

   int            n_cmp = 0;
   int            n_bad = 0;
   logic [2:0]    exp_q[$];
   int            busy_cycles = 0;
   int            last_run_len = 0;
   logic          prev_busy = 1'b0;

   always #5 clk = ~clk;

   multiplier_sequencer #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .lsb      (lsb),
      .rem_zero (rem_zero),
      .ps       (ps),
      .busy     (busy),
      .done     (done)
   );

   // Datapath multiplier register: loaded in LOAD, shifted right in SHIFT.
   assign lsb      = mreg[0];
   assign rem_zero = (mreg == '0);
   always @(posedge clk) begin
      if (ps == LOAD) mreg <= mult_in;
      else if (ps == SHIFT) mreg <= mreg >> 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected ps trace of one run for multiplier m, ending with the return to IDLE.
   task automatic push_run(input logic [W-1:0] m);
      bit early = 1'b0;
      exp_q.push_back(CLR);
      exp_q.push_back(LOAD);
      for (int i = 0; i < W; i++) begin
`ifdef MULT_SEQ_EARLY_TERM_EN
         if ((m >> i) == 0) begin
            exp_q.push_back(CHECK);
            early = 1'b1;
            break;
         end
`endif
         exp_q.push_back(CHECK);
         if (m[i]) exp_q.push_back(ADD);
         exp_q.push_back(SHIFT);
      end
      if (early) exp_q.push_back(LAST);
      else exp_q.push_back(LAST);
      exp_q.push_back(DONE);
      exp_q.push_back(IDLE);
   endtask

   function automatic int exp_len(input logic [W-1:0] m);
      int len = 2;
      for (int i = 0; i < W; i++) begin
`ifdef MULT_SEQ_EARLY_TERM_EN
         if ((m >> i) == 0) return len + 1 + 2;
`endif
         len += 2 + int'(m[i]);
      end
      return len + 2;
   endfunction

   // Monitor: every busy cycle and every return to IDLE consumes one expected entry.
   always @(negedge clk) begin
      if (busy === 1'b1 || prev_busy) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_output: got ps=%0b, expected no activity (t=%0t)", ps, $time);
         end else begin
            logic [2:0] e;
            e = exp_q.pop_front();
            chk("ps", ps, e);
            chk("busy", busy, (e != IDLE));
            chk("done", done, (e == DONE));
         end
      end
      if (busy === 1'b1) begin
         busy_cycles++;
      end else if (prev_busy) begin
         last_run_len = busy_cycles;
         busy_cycles  = 0;
      end
      prev_busy = (busy === 1'b1);
   end

   task automatic wait_drain();
      int c = 0;
      while (exp_q.size() != 0 && c < 200) begin
         @(negedge clk); #1;
         c++;
      end
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain_timeout: got %0d entries left, expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic wait_ps(input logic [2:0] code);
      int c = 0;
      while (ps !== code && c < 100) begin
         @(negedge clk); #1;
         c++;
      end
      if (ps !== code) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_ps: got %0b, expected %0b within budget", ps, code);
      end
   endtask

   task automatic do_run(input logic [W-1:0] m);
      mult_in = m;
      start   = 1'b1;
      push_run(m);
      @(posedge clk); #1;
      start = 1'b0;
      wait_drain();
      chk("run_len", last_run_len, exp_len(m));
   endtask

   initial begin
      int shifts;
      // Reset held with start high.
      mult_in = 4'b0101;
      start   = 1'b1;
      rst_n   = 1'b0;
      repeat (3) begin
         @(negedge clk); #1;
         chk("reset_ps", ps, IDLE);
         chk("reset_busy", busy, 1'b0);
         chk("reset_done", done, 1'b0);
      end
      rst_n = 1'b1;
      push_run(4'b0101);
      @(posedge clk); #1;
      chk("first_clr", ps, CLR);
      start = 1'b0;
      wait_drain();
      chk("run_len_0101", last_run_len, exp_len(4'b0101));

      do_run(4'b0000);
      do_run(4'b1111);

      // Start pulses during ADD and DONE are ignored.
      mult_in = 4'b1111;
      start   = 1'b1;
      push_run(4'b1111);
      @(posedge clk); #1;
      start = 1'b0;
      wait_ps(ADD);
      start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
      wait_ps(DONE);
      start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
      wait_drain();
      repeat (4) @(negedge clk);
      #1;

      // Start held high: DONE, IDLE, CLR back-to-back.
      mult_in = 4'($urandom_range(0, 15));
      start   = 1'b1;
      push_run(mult_in);
      push_run(mult_in);
      @(posedge clk); #1;
      wait_ps(DONE);
      @(negedge clk); #1;
      @(negedge clk); #1;
      start = 1'b0;
      wait_drain();
      chk("b2b_len", last_run_len, exp_len(mult_in));

      // Mid-run reset on the third SHIFT, then a full-length run.
      mult_in = 4'b0000;
      start   = 1'b1;
      push_run(4'b0000);
      @(posedge clk); #1;
      start  = 1'b0;
      shifts = 0;
      for (int c = 0; c < 100 && shifts < 3; c++) begin
         @(negedge clk); #1;
         if (ps == SHIFT) shifts++;
      end
      rst_n = 1'b0;
      exp_q.delete();
      exp_q.push_back(IDLE);
      @(negedge clk); #1;
      chk("midreset_ps", ps, IDLE);
      rst_n = 1'b1;
      @(negedge clk); #1;
      do_run(4'b0000);

      // Randomized runs.
      for (int r = 0; r < 20; r++) begin
         do_run(4'($urandom_range(0, 15)));
         repeat ($urandom_range(0, 3)) @(negedge clk);
         #1;
      end

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

endmodule
